// File: rtl/ctrl_iseq.sv
// ctrl_iseq: instruction sequencer. Holds a small program of instruction words
// and presents them one stage at a time to a downstream controller, handshaking
// on ptr_req_i. A frame runs from slot 0 up to the highest slot written since
// program mode was last entered.
// Optional build macro: CTRL_ISEQ_OVERRUN_EN adds the sticky overrun flag.
module ctrl_iseq #(
    parameter int unsigned REGFILE_ADDR_WIDTH = 3,
    parameter int unsigned DATA_ADDR_WIDTH    = 4,
    parameter int unsigned STAGE_WIDTH        = 3,
    localparam int unsigned IW = 2 + 2 * REGFILE_ADDR_WIDTH + 4 * DATA_ADDR_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   en_i,
    input  logic                   prog_i,
    input  logic                   start_i,
    input  logic                   wr_iw_i,
    input  logic [STAGE_WIDTH-1:0] wr_addr_i,
    input  logic [IW-1:0]          wr_data_i,
    input  logic                   ptr_req_i,
    output logic                   iw_valid_o,
    output logic [IW-1:0]          instr_word_o,
    output logic                   busy_o,
    output logic                   frame_done_o,
    output logic                   overrun_o
);

    typedef enum logic [1:0] {StIdle, StRead, StPresent, StDone} state_e;

    state_e                 state_q, state_d;
    logic [STAGE_WIDTH-1:0] stage_idx_q, stage_idx_d;
    logic [STAGE_WIDTH-1:0] last_stage_q, last_stage_d;
    logic                   programmed_q, programmed_d;
    logic                   prog_q, prog_d;
    logic [IW-1:0]          instr_word_q, instr_word_d;
    logic [IW-1:0]          store_q [2**STAGE_WIDTH];

    logic                   prog_rise;
    logic                   wr_en;
    logic [STAGE_WIDTH-1:0] last_base;

    assign prog_rise = en_i && prog_i && !prog_q;
    assign wr_en     = en_i && prog_i && wr_iw_i;
    // A write in the same cycle as the prog edge starts from a cleared program.
    assign last_base = prog_rise ? '0 : last_stage_q;

    // Program bookkeeping: prog edge detect, highest written slot, programmed flag.
    always_comb begin
        prog_d       = en_i ? prog_i : prog_q;
        last_stage_d = last_base;
        programmed_d = prog_rise ? 1'b0 : programmed_q;
        if (wr_en) begin
            programmed_d = 1'b1;
            if (wr_addr_i > last_base) begin
                last_stage_d = wr_addr_i;
            end
        end
    end

    // Sequencing FSM next-state, stage index and presented word.
    always_comb begin
        state_d      = state_q;
        stage_idx_d  = stage_idx_q;
        instr_word_d = instr_word_q;
        if (en_i) begin
            if (prog_i) begin
                state_d = StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start_i && programmed_q) begin
                            state_d     = StRead;
                            stage_idx_d = '0;
                        end
                    end
                    StRead: begin
                        // Latched here so store writes cannot disturb the held word.
                        instr_word_d = store_q[stage_idx_q];
                        state_d      = StPresent;
                    end
                    StPresent: begin
                        if (ptr_req_i) begin
                            if (stage_idx_q == last_stage_q) begin
                                state_d = StDone;
                            end else begin
                                stage_idx_d = stage_idx_q + STAGE_WIDTH'(1);
                                state_d     = StRead;
                            end
                        end
                    end
                    StDone: begin
                        state_d = StIdle;
                    end
                    default: begin
                        state_d = StIdle;
                    end
                endcase
            end
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            stage_idx_q  <= '0;
            last_stage_q <= '0;
            programmed_q <= 1'b0;
            prog_q       <= 1'b0;
            instr_word_q <= '0;
        end else begin
            state_q      <= state_d;
            stage_idx_q  <= stage_idx_d;
            last_stage_q <= last_stage_d;
            programmed_q <= programmed_d;
            prog_q       <= prog_d;
            instr_word_q <= instr_word_d;
        end
    end

    // Instruction store; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            store_q[wr_addr_i] <= wr_data_i;
        end
    end

`ifdef CTRL_ISEQ_OVERRUN_EN
    logic overrun_q, overrun_d;

    // Sticky flag for starts dropped because a frame was already running.
    always_comb begin
        overrun_d = overrun_q;
        if (prog_rise) begin
            overrun_d = 1'b0;
        end else if (en_i && !prog_i && start_i && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end
    end

    // Overrun register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun_o = overrun_q;
`else
    assign overrun_o = 1'b0;
`endif

    assign iw_valid_o   = (state_q == StPresent);
    assign busy_o       = (state_q != StIdle);
    assign frame_done_o = (state_q == StDone);
    assign instr_word_o = instr_word_q;

endmodule

// File: tb/tb_ctrl_iseq.sv
// Directed testbench for ctrl_iseq. Expected values are hand-derived from the
// sequencer's documented timing: start/ptr_req to iw_valid is two clock edges.
module tb_ctrl_iseq;

    localparam int IW = 24;

`ifdef CTRL_ISEQ_OVERRUN_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          en_i;
    logic          prog_i;
    logic          start_i;
    logic          wr_iw_i;
    logic [2:0]    wr_addr_i;
    logic [IW-1:0] wr_data_i;
    logic          ptr_req_i;
    logic          iw_valid_o;
    logic [IW-1:0] instr_word_o;
    logic          busy_o;
    logic          frame_done_o;
    logic          overrun_o;

    int total = 0;
    int bad   = 0;

    ctrl_iseq dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .en_i         (en_i),
        .prog_i       (prog_i),
        .start_i      (start_i),
        .wr_iw_i      (wr_iw_i),
        .wr_addr_i    (wr_addr_i),
        .wr_data_i    (wr_data_i),
        .ptr_req_i    (ptr_req_i),
        .iw_valid_o   (iw_valid_o),
        .instr_word_o (instr_word_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o),
        .overrun_o    (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr_slot(input logic [2:0] a, input logic [IW-1:0] d);
        wr_iw_i   = 1'b1;
        wr_addr_i = a;
        wr_data_i = d;
        step();
        wr_iw_i = 1'b0;
    endtask

    task automatic prog_enter();
        prog_i = 1'b1;
        step();
    endtask

    task automatic prog_exit();
        prog_i = 1'b0;
        step();
    endtask

    task automatic load_abc();
        prog_enter();
        wr_slot(3'd0, 24'h000011);
        wr_slot(3'd1, 24'h000022);
        wr_slot(3'd2, 24'h000033);
        prog_exit();
    endtask

    // Start a frame and stop once stage 1 is being presented.
    task automatic go_to_stage1();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        ptr_req_i = 1'b1;
        step();
        ptr_req_i = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        step();
        step();
        total++;
        if ({iw_valid_o, busy_o, frame_done_o, overrun_o} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags got v/b/d/o=%b%b%b%b want 0000",
                     iw_valid_o, busy_o, frame_done_o, overrun_o);
        end
        total++;
        if (instr_word_o !== 24'h0) begin
            bad++;
            $display("FAIL reset_word got %h want 000000", instr_word_o);
        end
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_sequence();
        logic [IW-1:0] exp_w [3];
        exp_w[0] = 24'h000011;
        exp_w[1] = 24'h000022;
        exp_w[2] = 24'h000033;
        load_abc();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        total++;
        if (iw_valid_o !== 1'b0 || busy_o !== 1'b1) begin
            bad++;
            $display("FAIL seq_read got v=%b b=%b want v=0 b=1", iw_valid_o, busy_o);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (iw_valid_o !== 1'b1 || instr_word_o !== exp_w[i]) begin
                bad++;
                $display("FAIL seq_word%0d got v=%b w=%h want v=1 w=%h",
                         i, iw_valid_o, instr_word_o, exp_w[i]);
            end
            ptr_req_i = 1'b1;
            step();
            ptr_req_i = 1'b0;
            if (i < 2) begin
                total++;
                if (iw_valid_o !== 1'b0 || frame_done_o !== 1'b0) begin
                    bad++;
                    $display("FAIL seq_gap%0d got v=%b d=%b want 0 0", i, iw_valid_o,
                             frame_done_o);
                end
            end
        end
        total++;
        if (frame_done_o !== 1'b1 || busy_o !== 1'b1 || iw_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL seq_done got d=%b b=%b v=%b want 1 1 0", frame_done_o, busy_o,
                     iw_valid_o);
        end
        step();
        total++;
        if (frame_done_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL seq_idle got d=%b b=%b want 0 0", frame_done_o, busy_o);
        end
    endtask

    task automatic test_unprogrammed();
        prog_enter();
        prog_exit();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({iw_valid_o, busy_o, frame_done_o} !== 3'b000) begin
                bad++;
                $display("FAIL unprog_c%0d got v/b/d=%b%b%b want 000", i, iw_valid_o,
                         busy_o, frame_done_o);
            end
            step();
        end
    endtask

    task automatic test_hold_and_enable();
        load_abc();
        go_to_stage1();
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (iw_valid_o !== 1'b1 || instr_word_o !== 24'h000022) begin
                bad++;
                $display("FAIL hold_c%0d got v=%b w=%h want v=1 w=000022", i, iw_valid_o,
                         instr_word_o);
            end
        end
        en_i      = 1'b0;
        ptr_req_i = 1'b1;
        start_i   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({iw_valid_o, busy_o, frame_done_o, overrun_o} !== 4'b1100 ||
                instr_word_o !== 24'h000022) begin
                bad++;
                $display("FAIL freeze_c%0d got v/b/d/o=%b%b%b%b w=%h want 1100 w=000022", i,
                         iw_valid_o, busy_o, frame_done_o, overrun_o, instr_word_o);
            end
        end
        en_i      = 1'b1;
        ptr_req_i = 1'b0;
        start_i   = 1'b0;
        ptr_req_i = 1'b1;
        step();
        ptr_req_i = 1'b0;
        step();
        total++;
        if (iw_valid_o !== 1'b1 || instr_word_o !== 24'h000033) begin
            bad++;
            $display("FAIL resume_word got v=%b w=%h want v=1 w=000033", iw_valid_o,
                     instr_word_o);
        end
        ptr_req_i = 1'b1;
        step();
        ptr_req_i = 1'b0;
        total++;
        if (frame_done_o !== 1'b1) begin
            bad++;
            $display("FAIL resume_done got d=%b want 1", frame_done_o);
        end
        step();
    endtask

    task automatic test_overrun();
        go_to_stage1();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        total++;
        if (iw_valid_o !== 1'b1 || instr_word_o !== 24'h000022 || frame_done_o !== 1'b0) begin
            bad++;
            $display("FAIL ovr_continue got v=%b w=%h d=%b want v=1 w=000022 d=0",
                     iw_valid_o, instr_word_o, frame_done_o);
        end
        ptr_req_i = 1'b1;
        step();
        ptr_req_i = 1'b0;
        step();
        ptr_req_i = 1'b1;
        step();
        ptr_req_i = 1'b0;
        total++;
        if (frame_done_o !== 1'b1) begin
            bad++;
            $display("FAIL ovr_done got d=%b want 1", frame_done_o);
        end
        // start in the DONE cycle must also be dropped
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({busy_o, frame_done_o, iw_valid_o} !== 3'b000) begin
                bad++;
                $display("FAIL ovr_noqueue_c%0d got b/d/v=%b%b%b want 000", i, busy_o,
                         frame_done_o, iw_valid_o);
            end
            step();
        end
        total++;
        if (overrun_o !== OVR_EXP) begin
            bad++;
            $display("FAIL ovr_flag got %b want %b", overrun_o, OVR_EXP);
        end
        prog_enter();
        total++;
        if (overrun_o !== 1'b0) begin
            bad++;
            $display("FAIL ovr_clear got %b want 0", overrun_o);
        end
        prog_exit();
    endtask

    task automatic test_abort();
        load_abc();
        go_to_stage1();
        prog_i = 1'b1;
        step();
        total++;
        if ({iw_valid_o, busy_o, frame_done_o} !== 3'b000) begin
            bad++;
            $display("FAIL prog_abort got v/b/d=%b%b%b want 000", iw_valid_o, busy_o,
                     frame_done_o);
        end
        wr_slot(3'd0, 24'h000011);
        wr_slot(3'd1, 24'h000022);
        wr_slot(3'd2, 24'h000033);
        prog_exit();
        go_to_stage1();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        total++;
        if ({iw_valid_o, busy_o, frame_done_o, overrun_o} !== 4'b0000 ||
            instr_word_o !== 24'h0) begin
            bad++;
            $display("FAIL rst_abort got v/b/d/o=%b%b%b%b w=%h want 0000 w=000000",
                     iw_valid_o, busy_o, frame_done_o, overrun_o, instr_word_o);
        end
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL rst_start_ignored got b=%b want 0", busy_o);
        end
        // Only slot 2 rewritten; slots 0 and 1 must still hold pre-reset data.
        prog_enter();
        wr_slot(3'd2, 24'h000044);
        prog_exit();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            logic [IW-1:0] w;
            w = (i == 0) ? 24'h000011 : (i == 1) ? 24'h000022 : 24'h000044;
            step();
            total++;
            if (iw_valid_o !== 1'b1 || instr_word_o !== w) begin
                bad++;
                $display("FAIL retain_word%0d got v=%b w=%h want v=1 w=%h", i, iw_valid_o,
                         instr_word_o, w);
            end
            ptr_req_i = 1'b1;
            step();
            ptr_req_i = 1'b0;
        end
        total++;
        if (frame_done_o !== 1'b1) begin
            bad++;
            $display("FAIL retain_done got d=%b want 1", frame_done_o);
        end
        step();
    endtask

    task automatic test_wrap();
        prog_enter();
        for (int i = 0; i < 8; i++) begin
            wr_slot(3'(i), 24'h0000A0 + 24'(i));
        end
        prog_exit();
        prog_enter();
        wr_slot(3'd7, 24'h000077);
        prog_exit();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [IW-1:0] w;
            w = (i == 7) ? 24'h000077 : 24'h0000A0 + 24'(i);
            step();
            total++;
            if (iw_valid_o !== 1'b1 || instr_word_o !== w) begin
                bad++;
                $display("FAIL wrap_word%0d got v=%b w=%h want v=1 w=%h", i, iw_valid_o,
                         instr_word_o, w);
            end
            ptr_req_i = 1'b1;
            step();
            ptr_req_i = 1'b0;
            if (i < 7) begin
                total++;
                if (frame_done_o !== 1'b0) begin
                    bad++;
                    $display("FAIL wrap_early_done%0d got d=%b want 0", i, frame_done_o);
                end
            end
        end
        total++;
        if (frame_done_o !== 1'b1) begin
            bad++;
            $display("FAIL wrap_done got d=%b want 1", frame_done_o);
        end
        step();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        total++;
        if (iw_valid_o !== 1'b1 || instr_word_o !== 24'h0000A0) begin
            bad++;
            $display("FAIL wrap_restart got v=%b w=%h want v=1 w=0000a0", iw_valid_o,
                     instr_word_o);
        end
        prog_enter();
        prog_exit();
    endtask

    initial begin
        rst_ni    = 1'b0;
        en_i      = 1'b1;
        prog_i    = 1'b0;
        start_i   = 1'b0;
        wr_iw_i   = 1'b0;
        wr_addr_i = '0;
        wr_data_i = '0;
        ptr_req_i = 1'b0;
        test_reset();
        test_sequence();
        test_unprogrammed();
        test_hold_and_enable();
        test_overrun();
        test_abort();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctrl_iseq.md
CTRL_ISEQ -- requirements
Module: ctrl_iseq

Interface
REQ-001 Parameter REGFILE_ADDR_WIDTH, default 3, SHALL set the register-file address field width.
REQ-002 Parameter DATA_ADDR_WIDTH, default 4, SHALL set the RAM pointer field width.
REQ-003 Parameter STAGE_WIDTH, default 3, SHALL set the stage index width (up to 2**STAGE_WIDTH stages).
REQ-004 IW = 2 + 2*REGFILE_ADDR_WIDTH + 4*DATA_ADDR_WIDTH (24 at defaults) SHALL be the instruction word width.
REQ-005 clk  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-006 rst  in  1  reset; synchronous, active-low.
REQ-007 en  in  1  global enable; 0 freezes all state.
REQ-008 prog  in  1  program mode; 1 aborts sequencing and permits writes.
REQ-009 start  in  1  one-cycle new-sample trigger.
REQ-010 wr_iw  in  1  instruction store write strobe.
REQ-011 wr_addr  in  STAGE_WIDTH  stage slot to write.
REQ-012 wr_data  in  IW  instruction word to write.
REQ-013 ptr_req  in  1  downstream controller accepts the presented word.
REQ-014 iw_valid  out  1  instr_word is valid and held.
REQ-015 instr_word  out  IW  current stage instruction word.
REQ-016 busy  out  1  a frame is in progress.
REQ-017 frame_done  out  1  one-cycle pulse after the last stage is accepted.
REQ-018 overrun  out  1  sticky flag: start arrived while busy.

Function
REQ-019 Store: 2**STAGE_WIDTH x IW array; write when prog=1, en=1, wr_iw=1; writes with prog=0 are ignored.
REQ-020 Rising edge of prog: last_stage and programmed cleared; each accepted write sets programmed=1 and last_stage=max(last_stage, wr_addr).
REQ-021 FSM states: IDLE, READ, PRESENT, DONE.
REQ-022 IDLE: iw_valid=0, busy=0; on start=1, prog=0, programmed=1, go to READ with stage_idx=0; start with programmed=0 is ignored.
REQ-023 READ (one cycle): instr_word loaded from store[stage_idx]; go to PRESENT.
REQ-024 PRESENT: iw_valid=1, instr_word stable until ptr_req=1.
REQ-025 ptr_req=1 in PRESENT: if stage_idx==last_stage go to DONE, else stage_idx+1 and go to READ; iw_valid SHALL be 0 the following cycle.
REQ-026 DONE (one cycle): frame_done=1; go to IDLE.
REQ-027 Latency: start to iw_valid=1 SHALL be 2 cycles; ptr_req to next iw_valid=1 SHALL be 2 cycles.
REQ-028 busy SHALL be 1 in READ, PRESENT and DONE.
REQ-029 ptr_req outside PRESENT SHALL be ignored.
REQ-030 en=0: state, stage_idx, outputs and store hold; start, ptr_req and wr_iw are ignored.
REQ-031 prog=1 in any state: next state IDLE, iw_valid=0, no frame_done pulse.
REQ-032 start with busy=1 SHALL be discarded (no queuing); the frame continues.
REQ-033 start in the DONE cycle SHALL be discarded.
REQ-034 A write to the slot currently in PRESENT SHALL not alter the held instr_word.

Reset
REQ-035 rst=0 at a clock edge: state IDLE, stage_idx=0, last_stage=0, programmed=0, iw_valid=0, instr_word=0, busy=0, frame_done=0, overrun=0.
REQ-036 Store contents SHALL not be reset.
REQ-037 Reset mid-frame SHALL abort the frame without a frame_done pulse.

Configuration
REQ-038 With CTRL_ISEQ_OVERRUN_EN defined: overrun is set by any start discarded under REQ-032/REQ-033 and cleared only by reset or by the rising edge of prog.
REQ-039 Without CTRL_ISEQ_OVERRUN_EN: overrun is constant 0 and no detection logic is built.

Verification
REQ-040 Write slots 0..2 with 0x000011, 0x000022, 0x000033, then prog=0 and start; ptr_req 1 cycle after each iw_valid -> words 0x000011, 0x000022, 0x000033 in order, iw_valid rise 2 cycles after each start/ptr_req, then one frame_done pulse and busy=0.
REQ-041 start with no writes since prog rose -> iw_valid, busy and frame_done stay 0.
REQ-042 Hold ptr_req=0 for 10 cycles in PRESENT at stage 1 -> instr_word stays 0x000022 and iw_valid stays 1; en=0 for 3 cycles -> all outputs frozen.
REQ-043 Second start during stage 1 -> ignored, one frame_done only; overrun=1 with CTRL_ISEQ_OVERRUN_EN defined, 0 without.
REQ-044 Assert prog, then rst=0, each during PRESENT at stage 1 -> next cycle iw_valid=0 and busy=0, no frame_done; after reset, start is ignored until slots are reprogrammed.
REQ-045 Write slot 7 only (last_stage=7) -> frame presents 8 words, stage_idx wraps cleanly to 0 on the next frame.
